// File: rtl/xf_test_pkg.sv
// Shared definitions for the transform-unit test harness: FSM states,
// CONTROL/STATUS bit positions and the register-map offset helpers.
package xf_test_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } stateT;

  localparam int CTRL_START   = 0;
  localparam int CTRL_BLOCK   = 1;
  localparam int CTRL_CLEAR   = 2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_TIMEOUT = 2;
  localparam int STAT_LAT_LSB = 16;

  // Word indices of the registers that follow the input block.
  function automatic int ctrlIndex(input int numIn);
    return numIn;
  endfunction

  function automatic int statusIndex(input int numIn);
    return numIn + 1;
  endfunction

  function automatic int outBaseIndex(input int numIn);
    return numIn + 2;
  endfunction

  function automatic int runCountIndex(input int numIn, input int numOut);
    return numIn + 2 + numOut;
  endfunction

endpackage

// File: rtl/xf_test_matrix_port.sv
// Registered matrix fetch port: serves one row of input-register words per
// request with a fixed one-cycle latency, word 0 in the MSBs.
module xf_test_matrix_port #(
  parameter int MAT_ROWS      = 3,
  parameter int MAT_ROW_WORDS = 3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [5:0]                        matAddr,
  input  logic                              matEnable,
  input  logic [MAT_ROWS*MAT_ROW_WORDS*32-1:0] regWords,
  output logic [MAT_ROW_WORDS*32-1:0]       matData,
  output logic                              matValid
);

  logic [MAT_ROW_WORDS*32-1:0] rowData;

  // Rows beyond MAT_ROWS never match and therefore read as zero.
  always_comb begin
    rowData = '0;
    for (int r = 0; r < MAT_ROWS; r++) begin
      for (int k = 0; k < MAT_ROW_WORDS; k++) begin
        if (32'(matAddr) == r) begin
          rowData[(MAT_ROW_WORDS-1-k)*32 +: 32] = regWords[(r*MAT_ROW_WORDS+k)*32 +: 32];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      matValid <= 1'b0;
      matData  <= '0;
    end else begin
      matValid <= matEnable;
      if (matEnable) begin
        matData <= rowData;
      end
    end
  end

endmodule

// File: rtl/xf_unit_test_core.sv
// Avalon-MM test harness for a transform sub-unit using the cycle/ready/
// dataValid handshake: input registers, latched results, status and watchdog.
module xf_unit_test_core
  import xf_test_pkg::*;
#(
  parameter int NUM_IN        = 18,
  parameter int NUM_OUT       = 9,
  parameter int MAT_ROWS      = 3,
  parameter int MAT_ROW_WORDS = 3,
  parameter int ADDR_W        = 8,
  parameter int TIMEOUT       = 1024
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADDR_W-1:0]            address,
  input  logic                         read,
  input  logic                         write,
  input  logic [31:0]                  writeData,
  output logic [31:0]                  readData,
  output logic                         waitrequest,
  output logic                         dutCycle,
  input  logic                         dutReady,
  input  logic                         dutDataValid,
  output logic [NUM_IN*32-1:0]         dutIn,
  input  logic [NUM_OUT*32-1:0]        dutOut,
  input  logic [5:0]                   matAddr,
  input  logic                         matEnable,
  output logic [MAT_ROW_WORDS*32-1:0]  matData,
  output logic                         matValid
);

  localparam int CTRL_IDX   = ctrlIndex(NUM_IN);
  localparam int STATUS_IDX = statusIndex(NUM_IN);
  localparam int OUT_BASE   = outBaseIndex(NUM_IN);
  localparam int RUN_IDX    = runCountIndex(NUM_IN, NUM_OUT);
  localparam int MAT_WORDS  = MAT_ROWS * MAT_ROW_WORDS;
  localparam int MAT_SRC    = (NUM_IN < MAT_WORDS) ? NUM_IN : MAT_WORDS;

  stateT       state, stateNext;
  logic [31:0] wordIdx;
  logic [31:0] inRegs  [NUM_IN];
  logic [31:0] outRegs [NUM_OUT];
  logic [31:0] runCount;
  logic [15:0] latency, waitCount, waitCountInc;
  logic        doneFlag, timeoutFlag, blockMode;
  logic        ctrlWrite, startReq, clearReq, inWrite;
  logic        issueFire, dataExit, timeoutExit, exitNow;
  logic [1:0]  unusedAddrBits;
  logic [MAT_WORDS*32-1:0] matWords;

  assign unusedAddrBits = address[1:0];
  assign wordIdx        = 32'(address[ADDR_W-1:2]);

  // CONTROL actions only take effect from IDLE; a held blocking write that
  // completes on WAIT exit must not restart the unit.
  assign ctrlWrite    = write && (wordIdx == CTRL_IDX);
  assign startReq     = ctrlWrite && writeData[CTRL_START] && (state == S_IDLE);
  assign clearReq     = ctrlWrite && writeData[CTRL_CLEAR] && (state == S_IDLE);
  assign waitCountInc = (waitCount == 16'hFFFF) ? waitCount : waitCount + 16'd1;
  assign issueFire    = (state == S_ISSUE) && dutReady;
  assign dataExit     = (state == S_WAIT) && dutDataValid;
  assign timeoutExit  = (state == S_WAIT) && !dutDataValid && (32'(waitCountInc) == TIMEOUT);
  assign exitNow      = dataExit || timeoutExit;
  assign dutCycle     = issueFire;
  assign inWrite      = write && !waitrequest && (wordIdx < NUM_IN);

  always_comb begin
    waitrequest = 1'b0;
    if (write) begin
      if (state == S_IDLE) begin
        waitrequest = startReq && writeData[CTRL_BLOCK];
      end else if ((wordIdx < NUM_IN) || (wordIdx == CTRL_IDX)) begin
        waitrequest = !(blockMode && exitNow);
      end
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      S_IDLE:  if (startReq) stateNext = S_ISSUE;
      S_ISSUE: if (dutReady) stateNext = S_WAIT;
      S_WAIT:  if (exitNow)  stateNext = S_IDLE;
      default: stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // waitCountInc counts the current WAIT cycle, so a next-cycle answer reports 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_IN; i++) inRegs[i] <= '0;
      for (int j = 0; j < NUM_OUT; j++) outRegs[j] <= '0;
      runCount    <= '0;
      latency     <= '0;
      waitCount   <= '0;
      doneFlag    <= 1'b0;
      timeoutFlag <= 1'b0;
      blockMode   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (inWrite && (wordIdx == i)) inRegs[i] <= writeData;
      end
      if (clearReq || startReq) begin
        doneFlag    <= 1'b0;
        timeoutFlag <= 1'b0;
      end
      if (startReq) begin
        blockMode <= writeData[CTRL_BLOCK];
      end
      if (issueFire) begin
        waitCount <= '0;
      end else if ((state == S_WAIT) && !exitNow) begin
        waitCount <= waitCountInc;
      end
      if (dataExit) begin
        for (int j = 0; j < NUM_OUT; j++) outRegs[j] <= dutOut[32*j +: 32];
        latency  <= waitCountInc;
        runCount <= runCount + 32'd1;
        doneFlag <= 1'b1;
      end
      if (timeoutExit) begin
        timeoutFlag <= 1'b1;
      end
    end
  end

  always_comb begin
    readData = '0;
    if (read) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (wordIdx == i) readData = inRegs[i];
      end
      if (wordIdx == STATUS_IDX) begin
        readData[STAT_BUSY]               = (state != S_IDLE);
        readData[STAT_DONE]               = doneFlag;
        readData[STAT_TIMEOUT]            = timeoutFlag;
        readData[STAT_LAT_LSB +: 16]      = latency;
      end
      for (int j = 0; j < NUM_OUT; j++) begin
        if (wordIdx == OUT_BASE + j) readData = outRegs[j];
      end
      if (wordIdx == RUN_IDX) readData = runCount;
    end
  end

  for (genvar g = 0; g < NUM_IN; g++) begin : gDutIn
    assign dutIn[32*g +: 32] = inRegs[g];
  end

  always_comb begin
    matWords = '0;
    matWords[MAT_SRC*32-1:0] = dutIn[MAT_SRC*32-1:0];
  end

  xf_test_matrix_port #(
    .MAT_ROWS      (MAT_ROWS),
    .MAT_ROW_WORDS (MAT_ROW_WORDS)
  ) uMatrixPort (
    .clk       (clk),
    .reset     (reset),
    .matAddr   (matAddr),
    .matEnable (matEnable),
    .regWords  (matWords),
    .matData   (matData),
    .matValid  (matValid)
  );

endmodule

// File: tb/tb_xf_unit_test_core.sv
// Self-checking bench for xf_unit_test_core: a stub unit with programmable
// answer delay, a table of start scenarios and randomized runs vs a model.
module tb_xf_unit_test_core;

  localparam int NUM_IN        = 18;
  localparam int NUM_OUT       = 9;
  localparam int MAT_ROWS      = 3;
  localparam int MAT_ROW_WORDS = 3;
  localparam int ADDR_W        = 8;
  localparam int TIMEOUT       = 16;
  localparam int CTRL_W        = NUM_IN;
  localparam int STATUS_W      = NUM_IN + 1;
  localparam int OUT_W         = NUM_IN + 2;
  localparam int RUN_W         = NUM_IN + 2 + NUM_OUT;

  logic                        clk = 1'b0;
  logic                        reset = 1'b1;
  logic [ADDR_W-1:0]           address;
  logic                        read, write;
  logic [31:0]                 writeData, readData;
  logic                        waitrequest, dutCycle, dutReady, dutDataValid;
  logic [NUM_IN*32-1:0]        dutIn;
  logic [NUM_OUT*32-1:0]       dutOut;
  logic [5:0]                  matAddr;
  logic                        matEnable;
  logic [MAT_ROW_WORDS*32-1:0] matData;
  logic                        matValid;

  always #5 clk = ~clk;

  xf_unit_test_core #(
    .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .MAT_ROWS(MAT_ROWS),
    .MAT_ROW_WORDS(MAT_ROW_WORDS), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .writeData(writeData), .readData(readData), .waitrequest(waitrequest),
    .dutCycle(dutCycle), .dutReady(dutReady), .dutDataValid(dutDataValid),
    .dutIn(dutIn), .dutOut(dutOut), .matAddr(matAddr), .matEnable(matEnable),
    .matData(matData), .matValid(matValid)
  );

  typedef struct {
    logic [31:0] ctrl;
    int          delay;
    logic [31:0] expStatus;
    logic [31:0] expRun;
    int          expStalls;
  } vecT;

  int          total = 0;
  int          bad = 0;
  logic [31:0] modelIn  [NUM_IN];
  logic [31:0] modelOut [NUM_OUT];
  logic [31:0] stubWords[NUM_OUT];
  logic [31:0] modelRun;
  logic [15:0] modelLat;
  logic        modelDone, modelTo;
  int          stubDelay = 0;
  int          stubCount = 0;
  vecT         vecs[9];

  // Stub unit: answers stubDelay cycles after the dutCycle pulse (0 = never).
  always @(posedge clk) begin
    if (dutCycle) stubCount = 1;
    else if (dutDataValid) stubCount = 0;
    else if (stubCount > 0 && stubCount < 100000) stubCount++;
    #1 dutDataValid = (stubDelay > 0) && (stubCount == stubDelay);
  end

  function automatic logic [7:0] wordAddr(input int idx);
    return 8'(idx * 4);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic busRead(input int idx, output logic [31:0] data);
    @(negedge clk);
    address = wordAddr(idx);
    read = 1'b1;
    #1 data = readData;
    read = 1'b0;
  endtask

  task automatic busWrite(input int idx, input logic [31:0] data, output int stalls);
    stalls = 0;
    @(negedge clk);
    address = wordAddr(idx);
    writeData = data;
    write = 1'b1;
    #1;
    while (waitrequest && stalls < 200) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    if (waitrequest) begin
      checkOutput("writeStallBound", 32'd1, 32'd0);
      write = 1'b0;
      return;
    end
    @(posedge clk);
    #1 write = 1'b0;
  endtask

  task automatic waitIdle();
    logic [31:0] s;
    for (int n = 0; n < 300; n++) begin
      busRead(STATUS_W, s);
      if (!s[0]) return;
    end
    checkOutput("idleWaitBound", 32'd1, 32'd0);
  endtask

  // Runs one CONTROL write against the stub and advances the reference model.
  task automatic applyStimulus(input logic [31:0] ctrl, input int delay, input int gap, output int stalls);
    for (int j = 0; j < NUM_OUT; j++) begin
      stubWords[j] = $urandom;
      dutOut[j*32 +: 32] = stubWords[j];
    end
    stubDelay = delay;
    if (gap > 0) dutReady = 1'b0;
    busWrite(CTRL_W, ctrl, stalls);
    if (ctrl[0] && !ctrl[1]) begin
      @(negedge clk);
      address = wordAddr(0);
      writeData = 32'hDEAD_BEEF;
      write = 1'b1;
      #1 checkOutput("busyInputStall", {31'd0, waitrequest}, 32'd1);
      write = 1'b0;
      repeat (gap) @(negedge clk);
      dutReady = 1'b1;
      waitIdle();
    end
    if (ctrl[2]) begin
      modelDone = 1'b0;
      modelTo = 1'b0;
    end
    if (ctrl[0]) begin
      modelDone = 1'b0;
      modelTo = 1'b0;
      if (delay >= 1 && delay <= TIMEOUT) begin
        modelOut = stubWords;
        modelLat = 16'(delay);
        modelRun = modelRun + 1;
        modelDone = 1'b1;
      end else begin
        modelTo = 1'b1;
      end
    end
  endtask

  task automatic checkResults(input string tag, input logic [31:0] expStatus, input logic [31:0] expRun);
    logic [31:0] d;
    busRead(STATUS_W, d);
    checkOutput({tag, ".status"}, d, expStatus);
    busRead(RUN_W, d);
    checkOutput({tag, ".runCount"}, d, expRun);
    for (int j = 0; j < NUM_OUT; j++) begin
      busRead(OUT_W + j, d);
      checkOutput($sformatf("%s.out%0d", tag, j), d, modelOut[j]);
    end
  endtask

  task automatic checkMatrix(input int row);
    logic [31:0] expWord;
    @(negedge clk);
    matAddr = 6'(row);
    matEnable = 1'b1;
    @(negedge clk);
    matEnable = 1'b0;
    checkOutput($sformatf("matValid%0d", row), {31'd0, matValid}, 32'd1);
    for (int k = 0; k < MAT_ROW_WORDS; k++) begin
      expWord = (row < MAT_ROWS) ? modelIn[row*MAT_ROW_WORDS + k] : 32'd0;
      checkOutput($sformatf("matData%0d.w%0d", row, k), matData[(MAT_ROW_WORDS-1-k)*32 +: 32], expWord);
    end
    @(negedge clk);
    checkOutput("matValidDrop", {31'd0, matValid}, 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    int          stalls, expStalls, idx, delay, gap;
    logic [31:0] ctrl;

    address = '0; read = 1'b0; write = 1'b0; writeData = '0;
    dutReady = 1'b1; dutDataValid = 1'b0; dutOut = '0;
    matAddr = '0; matEnable = 1'b0;
    for (int i = 0; i < NUM_IN; i++) modelIn[i] = '0;
    for (int j = 0; j < NUM_OUT; j++) modelOut[j] = '0;
    modelRun = '0; modelLat = '0; modelDone = 1'b0; modelTo = 1'b0;

    vecs[0] = '{32'h1, 4,  32'h0004_0002, 32'd1, 0};
    vecs[1] = '{32'h3, 3,  32'h0003_0002, 32'd2, 4};
    vecs[2] = '{32'h1, 0,  32'h0003_0004, 32'd2, 0};
    vecs[3] = '{32'h4, 0,  32'h0003_0000, 32'd2, 0};
    vecs[4] = '{32'h3, 0,  32'h0003_0004, 32'd2, 17};
    vecs[5] = '{32'h5, 16, 32'h0010_0002, 32'd3, 0};
    vecs[6] = '{32'h3, 17, 32'h0010_0004, 32'd3, 17};
    vecs[7] = '{32'h3, 1,  32'h0001_0002, 32'd4, 2};
    vecs[8] = '{32'h1, 2,  32'h0002_0002, 32'd5, 0};

    repeat (3) @(negedge clk);
    #1;
    checkOutput("resetWaitreq", {31'd0, waitrequest}, 32'd0);
    checkOutput("resetDutCycle", {31'd0, dutCycle}, 32'd0);
    checkOutput("resetMatValid", {31'd0, matValid}, 32'd0);
    checkOutput("resetReadData", readData, 32'd0);
    reset = 1'b0;

    checkResults("reset", 32'd0, 32'd0);

    for (int i = 0; i < NUM_IN; i++) begin
      busWrite(i, 32'h100 + 32'(i), stalls);
      modelIn[i] = 32'h100 + 32'(i);
    end
    for (int i = 0; i < NUM_IN; i++) begin
      busRead(i, d);
      checkOutput($sformatf("inReadback%0d", i), d, modelIn[i]);
    end
    checkOutput("dutInWord5", dutIn[5*32 +: 32], 32'h105);
    busRead(CTRL_W, d);
    checkOutput("controlReadsZero", d, 32'd0);
    busRead(RUN_W + 1, d);
    checkOutput("unmappedReadsZero", d, 32'd0);

    checkMatrix(1);
    checkMatrix(3);

    for (int v = 0; v < 9; v++) begin
      applyStimulus(vecs[v].ctrl, vecs[v].delay, 0, stalls);
      checkOutput($sformatf("vec%0d.stalls", v), 32'(stalls), 32'(vecs[v].expStalls));
      checkResults($sformatf("vec%0d", v), vecs[v].expStatus, vecs[v].expRun);
    end
    busRead(0, d);
    checkOutput("busyWriteDropped", d, modelIn[0]);

    for (int it = 0; it < 20; it++) begin
      for (int w = 0; w < 2; w++) begin
        idx = $urandom_range(0, NUM_IN - 1);
        d = $urandom;
        busWrite(idx, d, stalls);
        modelIn[idx] = d;
      end
      ctrl  = {29'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1};
      delay = $urandom_range(0, 20);
      gap   = ctrl[1] ? 0 : $urandom_range(0, 3);
      applyStimulus(ctrl, delay, gap, stalls);
      expStalls = !ctrl[1] ? 0 : ((delay >= 1 && delay <= TIMEOUT) ? delay : TIMEOUT) + 1;
      checkOutput($sformatf("rand%0d.stalls", it), 32'(stalls), 32'(expStalls));
      checkResults($sformatf("rand%0d", it), {modelLat, 13'd0, modelTo, modelDone, 1'b0}, modelRun);
    end
    for (int i = 0; i < NUM_IN; i++) begin
      busRead(i, d);
      checkOutput($sformatf("randInReadback%0d", i), d, modelIn[i]);
    end
    checkMatrix($urandom_range(0, 2));
    checkMatrix($urandom_range(3, 5));

    @(negedge clk);
    dutReady = 1'b0;
    stubDelay = 0;
    address = wordAddr(CTRL_W);
    writeData = 32'h3;
    write = 1'b1;
    #1 checkOutput("blockingStartStall", {31'd0, waitrequest}, 32'd1);
    @(negedge clk);
    #1 checkOutput("issueHeldStall", {31'd0, waitrequest}, 32'd1);
    checkOutput("noCycleWithoutReady", {31'd0, dutCycle}, 32'd0);
    dutReady = 1'b1;
    #1 checkOutput("issuePulse", {31'd0, dutCycle}, 32'd1);
    reset = 1'b1;
    #1 checkOutput("asyncCycleDrop", {31'd0, dutCycle}, 32'd0);
    write = 1'b0;
    #1 checkOutput("resetWaitreqDrop", {31'd0, waitrequest}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NUM_IN; i++) modelIn[i] = '0;
    for (int j = 0; j < NUM_OUT; j++) modelOut[j] = '0;
    checkResults("midReset", 32'd0, 32'd0);
    busRead(0, d);
    checkOutput("midResetIn0", d, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
